cpu_ifetch_q: RTL and testbench
===============================

Name: cpu_ifetch_q

Overview:
- Parametrised instruction-fetch unit with an in-order prefetch queue, for the next-generation cpu pipeline.
- Issues sequential instruction reads to an instruction memory that may accept requests with variable latency and keep several reads outstanding.
- Buffers returned words with their PC and presents them to decode over a valid/ready handshake.
- Handles branch redirects by flushing the queue and discarding responses still in flight.

Parameters:
- AW, 16, address/PC width in words.
- DW, 16, instruction word width.
- DEPTH, 4, queue entries; power of two, >= 2. Also the hard limit on (queued + outstanding).
- RESET_PC, 0, fetch PC after reset.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- mem_addr  out  AW  fetch address (= fetch_pc).
- mem_req  out  1  request valid.
- mem_ack  in  1  request accepted this cycle (mem_req & mem_ack = issue).
- mem_rvalid  in  1  response valid; responses return in issue order.
- mem_rdata  in  DW  response word.
- redirect  in  1  branch taken; flush.
- redirect_pc  in  AW  new fetch PC.
- out_valid  out  1  queue head valid.
- out_ir  out  DW  head instruction.
- out_pc  out  AW  head PC.
- out_ready  in  1  decode consumes head (pop = out_valid & out_ready).
- occupancy  out  $clog2(DEPTH)+1  queued entry count.

Behaviour:
- Reset (async assert, sync release): fetch_pc=RESET_PC, queue empty, outstanding=0, drop_cnt=0, out_valid=0, mem_req=0, occupancy=0. out_ir and out_pc are don't-care.
- Credit rule: mem_req = reset_n & ~redirect & (occupancy + outstanding < DEPTH).
- On issue: fetch_pc <= fetch_pc+1, wrapping modulo 2^AW. A PC FIFO (depth DEPTH) records the issued address.
- outstanding tracking: +1 on issue, -1 on mem_rvalid, both in the same cycle gives net 0.
- Response handling:
  - drop_cnt>0: word discarded, drop_cnt decrements.
  - drop_cnt=0: word pushed with its recorded PC.
  - mem_rvalid with outstanding=0: protocol error; ignore the response and leave all counters unchanged.
- Queue:
  - Registered. A pushed word is visible on out_valid the cycle after mem_rvalid.
  - Push and pop in the same cycle are allowed, including when full, since credit guarantees room.
  - Pointers wrap at DEPTH.
- Redirect (single cycle):
  - Queue and PC FIFO cleared; fetch_pc <= redirect_pc.
  - drop_cnt <= outstanding - (mem_rvalid ? 1 : 0) + drop_cnt adjustment; precisely, the count of responses still owed after this cycle.
  - Any mem_rvalid in the redirect cycle is discarded. No issue in the redirect cycle.
  - out_valid=0 the next cycle. A pop in the redirect cycle is honoured by decode but has no queue effect.
- Issue at the new PC starts the cycle after redirect. The first new word is visible on out_valid no earlier than 2 cycles after issue, and only after all dropped responses have returned.
- Back-to-back redirects: each redirect recomputes drop_cnt from the current outstanding count, so nothing is double-counted.
- out_ready low indefinitely: the queue fills; once occupancy+outstanding=DEPTH, mem_req drops.

Optional Feature:
- Macro CPU_IFETCH_BYPASS_EN.
- Defined: when the queue is empty, drop_cnt=0, there is no redirect, and mem_rvalid is high, the response is presented combinationally the same cycle (out_valid=1, out_ir=mem_rdata, out_pc=PC FIFO head).
  - If out_ready is high, the word is consumed and not pushed.
  - Otherwise it is pushed as normal.
- Not defined: no combinational path from mem_* to out_*; minimum response-to-out_valid latency is 1 cycle.

Decomposition:
- Package cpu_ifetch_pkg holds:
  - typedef fetch_entry_t {pc, ir}, parametrised via localparams matching the AW/DW defaults;
  - the function clog2-based CNT_W;
  - constant IFETCH_DEPTH_MIN=2.
- Sub-module cpu_ifetch_fifo: generic synchronous FIFO (WIDTH, DEPTH, flush input), instantiated twice — once for the PC FIFO, once for the entry queue.

Test Plan:
- Zero-wait memory (mem_ack=1, rvalid one cycle after issue), out_ready=1 → out_pc sequence 0,1,2,3… one per cycle after a 2-cycle fill; occupancy ≤1.
- out_ready=0, DEPTH=4 → exactly 4 issues (addr 0..3), then mem_req=0, occupancy=4. Release out_ready → pops PCs 0,1,2,3 in order and issue resumes at addr 4.
- Memory latency 3 with 3 outstanding; redirect to 0x0100 → the 3 returning words are dropped; first out_pc=0x0100 with the correct word; no stale word ever reaches out_valid.
- Redirect coincident with mem_rvalid and pop → the response is dropped, drop_cnt equals outstanding-1, the queue is empty next cycle, and issue resumes at redirect_pc.
- Fetch starting at 0xFFFE → out_pc sequence FFFE, FFFF, 0000, 0001.
- reset_n asserted mid-burst with 2 outstanding → outputs clear immediately. After release, fetch restarts at RESET_PC; responses the memory model aborted on reset are not expected.

Source files
------------

// File: rtl/cpu_ifetch_pkg.sv
// Shared sizing constants, entry type and counter-width helper for the cpu_ifetch_q slice.
package cpu_ifetch_pkg;

  localparam int IFETCH_AW        = 16;
  localparam int IFETCH_DW        = 16;
  localparam int IFETCH_DEPTH     = 4;
  localparam int IFETCH_DEPTH_MIN = 2;

  typedef struct packed {
    logic [IFETCH_AW-1:0] pc;
    logic [IFETCH_DW-1:0] ir;
  } fetch_entry_t;

  // Counter width able to hold 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int CNT_W = cnt_w(IFETCH_DEPTH);

endpackage

// File: rtl/cpu_ifetch_q_if.sv
// Fetch-unit bus: instruction-memory request/response plus the decode-side valid/ready handshake.
interface cpu_ifetch_q_if
  import cpu_ifetch_pkg::*;
#(
  parameter int AW = IFETCH_AW,
  parameter int DW = IFETCH_DW
);

  logic [AW-1:0] mem_addr;
  logic          mem_req;
  logic          mem_ack;
  logic          mem_rvalid;
  logic [DW-1:0] mem_rdata;

  logic          out_valid;
  logic [DW-1:0] out_ir;
  logic [AW-1:0] out_pc;
  logic          out_ready;

  modport master (
    output mem_addr, mem_req,
    input  mem_ack, mem_rvalid, mem_rdata,
    output out_valid, out_ir, out_pc,
    input  out_ready
  );

  modport slave (
    input  mem_addr, mem_req,
    output mem_ack, mem_rvalid, mem_rdata,
    input  out_valid, out_ir, out_pc,
    output out_ready
  );

endinterface

// File: rtl/cpu_ifetch_fifo.sv
// Generic synchronous FIFO with flush; head word is read straight from storage (show-ahead).
module cpu_ifetch_fifo
  import cpu_ifetch_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = IFETCH_DEPTH
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      flush,
  input  logic                      push,
  input  logic [WIDTH-1:0]          push_data,
  input  logic                      pop,
  output logic [WIDTH-1:0]          head_data,
  output logic                      empty,
  output logic                      full,
  output logic [cnt_w(DEPTH)-1:0]   count
);

  // Clamp keeps the pointer at least one bit wide for the smallest legal depth.
  localparam int PTR_W = $clog2((DEPTH < IFETCH_DEPTH_MIN) ? IFETCH_DEPTH_MIN : DEPTH);
  localparam int CW    = cnt_w(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             do_push;
  logic             do_pop;

  assign empty     = (count_reg == '0);
  assign full      = (count_reg == CW'(DEPTH));
  assign count     = count_reg;
  assign head_data = mem[rd_ptr_reg];

  // A push into a full FIFO is legal only when the head leaves in the same cycle.
  assign do_push = push & (~full | pop);
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      count_reg <= count_reg + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr_reg] <= push_data;
  end

endmodule

// File: rtl/cpu_ifetch_q.sv
// Instruction-fetch unit: credit-limited sequential fetch, in-order prefetch queue, redirect flush.
// Optional same-cycle response bypass to decode is enabled by defining CPU_IFETCH_BYPASS_EN.
module cpu_ifetch_q
  import cpu_ifetch_pkg::*;
#(
  parameter int            AW       = IFETCH_AW,
  parameter int            DW       = IFETCH_DW,
  parameter int            DEPTH    = IFETCH_DEPTH,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     reset_n,
  cpu_ifetch_q_if.master           bus,
  input  logic                     redirect,
  input  logic [AW-1:0]            redirect_pc,
  output logic [cnt_w(DEPTH)-1:0]  occupancy
);

  localparam int CW = cnt_w(DEPTH);
  localparam int EW = AW + DW;

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [DW-1:0] ir;
  } entry_t;

  logic [AW-1:0] fetch_pc_reg,    fetch_pc_next;
  logic [CW-1:0] outstanding_reg, outstanding_next;
  logic [CW-1:0] drop_cnt_reg,    drop_cnt_next;

  logic          issue;
  logic          rsp_ok;
  logic          rsp_live;
  logic          bypass_hit;
  logic          bypass_take;
  logic          q_push;
  logic          q_pop;
  logic [CW:0]   credit_used;

  logic [AW-1:0] pc_head;
  logic          pc_empty;
  logic          pc_full;
  logic [CW-1:0] pc_count;

  entry_t        q_in;
  logic [EW-1:0] q_head_bits;
  entry_t        q_head;
  logic          q_empty;
  logic          q_full;
  logic [CW-1:0] q_count;
  logic          unused_flags;

  // Every queued entry plus every owed response (live or dropped) holds a credit.
  assign credit_used  = {1'b0, q_count} + {1'b0, outstanding_reg};
  assign bus.mem_req  = reset_n & ~redirect & (credit_used < (CW+1)'(DEPTH));
  assign bus.mem_addr = fetch_pc_reg;
  assign issue        = bus.mem_req & bus.mem_ack;

  // A response with nothing owed is a protocol error and is ignored entirely.
  assign rsp_ok   = bus.mem_rvalid & (outstanding_reg != '0);
  assign rsp_live = rsp_ok & ~redirect & (drop_cnt_reg == '0);

  assign q_in   = '{pc: pc_head, ir: bus.mem_rdata};
  assign q_head = entry_t'(q_head_bits);

`ifdef CPU_IFETCH_BYPASS_EN
  assign bypass_hit    = rsp_live & q_empty;
  assign bus.out_valid = ~q_empty | bypass_hit;
  assign bus.out_ir    = bypass_hit ? bus.mem_rdata : q_head.ir;
  assign bus.out_pc    = bypass_hit ? pc_head       : q_head.pc;
`else
  assign bypass_hit    = 1'b0;
  assign bus.out_valid = ~q_empty;
  assign bus.out_ir    = q_head.ir;
  assign bus.out_pc    = q_head.pc;
`endif

  assign bypass_take = bypass_hit & bus.out_ready;
  assign q_push      = rsp_live & ~bypass_take;
  assign q_pop       = ~q_empty & bus.out_ready & ~redirect;
  assign occupancy   = q_count;

  always_comb begin
    fetch_pc_next    = fetch_pc_reg;
    outstanding_next = outstanding_reg + CW'(issue) - CW'(rsp_ok);
    drop_cnt_next    = drop_cnt_reg;
    if (issue) fetch_pc_next = fetch_pc_reg + AW'(1);
    if (redirect) begin
      // Everything still owed after this cycle belongs to the abandoned path.
      fetch_pc_next = redirect_pc;
      drop_cnt_next = outstanding_reg - CW'(rsp_ok);
    end else if (rsp_ok && (drop_cnt_reg != '0)) begin
      drop_cnt_next = drop_cnt_reg - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc_reg    <= RESET_PC;
      outstanding_reg <= '0;
      drop_cnt_reg    <= '0;
    end else begin
      fetch_pc_reg    <= fetch_pc_next;
      outstanding_reg <= outstanding_next;
      drop_cnt_reg    <= drop_cnt_next;
    end
  end

  // Addresses of live requests, popped as their words come back.
  cpu_ifetch_fifo #(
    .WIDTH (AW),
    .DEPTH (DEPTH)
  ) u_pc_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (redirect),
    .push      (issue),
    .push_data (fetch_pc_reg),
    .pop       (rsp_live),
    .head_data (pc_head),
    .empty     (pc_empty),
    .full      (pc_full),
    .count     (pc_count)
  );

  cpu_ifetch_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_entry_q (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (redirect),
    .push      (q_push),
    .push_data (q_in),
    .pop       (q_pop),
    .head_data (q_head_bits),
    .empty     (q_empty),
    .full      (q_full),
    .count     (q_count)
  );

  assign unused_flags = ^{pc_empty, pc_full, pc_count, q_full};

  a_drop_bound: assert property (@(posedge clk) disable iff (!reset_n)
    drop_cnt_reg <= outstanding_reg);

  a_credit_bound: assert property (@(posedge clk) disable iff (!reset_n)
    credit_used <= (CW+1)'(DEPTH));

endmodule

// File: tb/tb_cpu_ifetch_q.sv
// Bench for cpu_ifetch_q: in-order memory model, queue/owed-response scoreboard checked every cycle,
// and directed scenarios with literal expectations on the consumed instruction stream.
module tb_cpu_ifetch_q;
  import cpu_ifetch_pkg::*;

  localparam int DEPTH = 4;
`ifdef CPU_IFETCH_BYPASS_EN
  localparam int BYP = 1;
`else
  localparam int BYP = 0;
`endif

  logic             clk = 1'b0;
  logic             reset_n;
  logic             redirect;
  logic [15:0]      redirect_pc;
  logic [CNT_W-1:0] occupancy;

  always #5 clk = ~clk;

  cpu_ifetch_q_if #(.AW(IFETCH_AW), .DW(IFETCH_DW)) bus ();

  cpu_ifetch_q #(
    .AW       (IFETCH_AW),
    .DW       (IFETCH_DW),
    .DEPTH    (DEPTH),
    .RESET_PC (16'h0000)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .bus         (bus),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .occupancy   (occupancy)
  );

  typedef struct { logic [15:0] addr; int due; } mreq_t;
  typedef struct { logic [15:0] addr; bit live; } owed_t;
  typedef struct { int cyc; logic [15:0] pc; logic [15:0] ir; } pop_t;

  mreq_t        mq[$];      // memory side: accepted requests awaiting their response slot
  owed_t        owed[$];    // model: responses the fetch unit is still owed, oldest first
  fetch_entry_t exp_q[$];   // model: words decode has not yet seen
  pop_t         pops[$];    // instructions actually consumed by decode
  logic [15:0]  issued[$];
  logic [15:0]  exp_pc;
  int           cyc;
  int           lat;
  bit           spurious;
  int           max_occ;
  int           n_cmp = 0;
  int           n_bad = 0;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] pop_pc(input int i);
    if (i < pops.size()) return {16'h0, pops[i].pc};
    return 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] pop_ir(input int i);
    if (i < pops.size()) return {16'h0, pops[i].ir};
    return 32'hFFFF_FFFF;
  endfunction

  function automatic int pop_cyc(input int i);
    if (i < pops.size()) return pops[i].cyc;
    return -1;
  endfunction

  // One clock cycle: drive memory response, compare against model, advance model and memory.
  task automatic step();
    bit          p_valid, p_req, byp, real_rsp;
    logic [15:0] p_pc, p_ir;
    owed_t       f;
    real_rsp = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 16'h0000;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      real_rsp       = 1'b1;
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = mem_word(mq[0].addr);
    end else if (spurious) begin
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = 16'hDEAD;
    end
    #1;
    byp = 1'b0;
`ifdef CPU_IFETCH_BYPASS_EN
    byp = (exp_q.size() == 0) && bus.mem_rvalid && !redirect && (owed.size() > 0) && owed[0].live;
`endif
    p_valid = (exp_q.size() > 0) || byp;
    p_pc = 16'h0000;
    p_ir = 16'h0000;
    if (byp) begin
      p_pc = owed[0].addr;
      p_ir = bus.mem_rdata;
    end else if (exp_q.size() > 0) begin
      p_pc = exp_q[0].pc;
      p_ir = exp_q[0].ir;
    end
    p_req = !redirect && ((exp_q.size() + owed.size()) < DEPTH);

    chk("out_valid", 32'(bus.out_valid), 32'(p_valid));
    if (p_valid) begin
      chk("out_pc", 32'(bus.out_pc), 32'(p_pc));
      chk("out_ir", 32'(bus.out_ir), 32'(p_ir));
    end
    chk("occupancy", 32'(occupancy), exp_q.size());
    chk("mem_req", 32'(bus.mem_req), 32'(p_req));
    if (p_req) chk("mem_addr", 32'(bus.mem_addr), 32'(exp_pc));

    if (bus.out_valid && bus.out_ready) begin
      pops.push_back('{cyc, bus.out_pc, bus.out_ir});
      $display("cyc %0d: decode takes pc=%04h ir=%04h", cyc, bus.out_pc, bus.out_ir);
    end
    if (int'(occupancy) > max_occ) max_occ = int'(occupancy);

    if (real_rsp) void'(mq.pop_front());
    if (bus.mem_req && bus.mem_ack) begin
      mq.push_back('{bus.mem_addr, cyc + lat});
      issued.push_back(bus.mem_addr);
    end

    if (redirect) begin
      if (bus.mem_rvalid && owed.size() > 0) void'(owed.pop_front());
      foreach (owed[i]) owed[i].live = 1'b0;
      exp_q.delete();
      exp_pc = redirect_pc;
    end else begin
      if (p_valid && bus.out_ready && !byp) void'(exp_q.pop_front());
      if (bus.mem_rvalid && owed.size() > 0) begin
        f = owed.pop_front();
        if (f.live && !(byp && bus.out_ready)) exp_q.push_back('{pc: f.addr, ir: bus.mem_rdata});
      end
      if (p_req && bus.mem_ack) begin
        owed.push_back('{exp_pc, 1'b1});
        exp_pc = exp_pc + 16'h0001;
      end
    end

    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  // Asserts reset immediately (possibly mid-cycle), checks cleared outputs, releases on a negedge.
  task automatic do_reset();
    reset_n        = 1'b0;
    redirect       = 1'b0;
    bus.out_ready  = 1'b0;
    bus.mem_ack    = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 16'h0000;
    spurious       = 1'b0;
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_mem_req", 32'(bus.mem_req), 0);
    chk("rst_occupancy", 32'(occupancy), 0);
    repeat (2) @(negedge clk);
    mq.delete();
    owed.delete();
    exp_q.delete();
    pops.delete();
    issued.delete();
    exp_pc  = 16'h0000;
    cyc     = 0;
    max_occ = 0;
    reset_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    redirect_pc = 16'h0000;
    lat = 1;
    do_reset();

    // Zero-wait memory, decode always ready; a stray rvalid with nothing owed in cycle 0.
    bus.out_ready = 1'b1;
    bus.mem_ack   = 1'b1;
    lat      = 1;
    spurious = 1'b1;
    step();
    spurious = 1'b0;
    repeat (9) step();
    chk("t1_first_pop_cyc", pop_cyc(0), 2 - BYP);
    for (int i = 0; i < 6; i++) chk("t1_pc_seq", pop_pc(i), i);
    chk("t1_ir0", pop_ir(0), 32'h5A3C);
    chk("t1_ir1", pop_ir(1), 32'h5B3C);
    chk("t1_max_occ", max_occ, 1 - BYP);

    // Decode stalled: exactly DEPTH issues, then credit exhausted.
    do_reset();
    bus.mem_ack   = 1'b1;
    bus.out_ready = 1'b0;
    lat = 1;
    repeat (8) step();
    chk("t2_issue_cnt", issued.size(), 4);
    for (int i = 0; i < 4 && i < issued.size(); i++) chk("t2_issue_addr", 32'(issued[i]), i);
    #1;
    chk("t2_mem_req_stall", 32'(bus.mem_req), 0);
    chk("t2_occ_full", 32'(occupancy), 4);
    bus.out_ready = 1'b1;
    repeat (8) step();
    for (int i = 0; i < 4; i++) chk("t2_drain_pc", pop_pc(i), i);
    chk("t2_drain_cyc", pop_cyc(0), 8);
    chk("t2_resume_addr", (issued.size() > 4) ? 32'(issued[4]) : 32'hFFFF_FFFF, 4);

    // Latency 3, three owed, redirect lands with the first response.
    do_reset();
    bus.mem_ack   = 1'b1;
    bus.out_ready = 1'b1;
    lat = 3;
    repeat (3) step();
    redirect    = 1'b1;
    redirect_pc = 16'h0100;
    step();
    redirect = 1'b0;
    repeat (8) step();
    chk("t3_first_pc", pop_pc(0), 32'h0100);
    chk("t3_first_ir", pop_ir(0), 32'h5A3D);
    chk("t3_first_cyc", pop_cyc(0), 8 - BYP);
    chk("t3_second_pc", pop_pc(1), 32'h0101);

    // Redirect coincident with a response and a pop.
    do_reset();
    bus.mem_ack   = 1'b1;
    bus.out_ready = 1'b1;
    lat = 2;
    repeat (6) step();
    redirect    = 1'b1;
    redirect_pc = 16'h0200;
    step();
    redirect = 1'b0;
    #1;
    chk("t4_valid_after", 32'(bus.out_valid), 0);
    chk("t4_occ_after", 32'(occupancy), 0);
    chk("t4_req_after", 32'(bus.mem_req), 1);
    chk("t4_addr_after", 32'(bus.mem_addr), 32'h0200);
    repeat (8) step();
    for (int i = 0; i < 4; i++) chk("t4_pre_pc", pop_pc(i), i);
    chk("t4_pop_in_redirect", pop_cyc(3), 6 - BYP);
    chk("t4_new_pc", pop_pc(4), 32'h0200);
    chk("t4_new_cyc", pop_cyc(4), 10 - BYP);

    // PC wrap-around.
    do_reset();
    bus.mem_ack   = 1'b1;
    bus.out_ready = 1'b1;
    lat = 1;
    redirect    = 1'b1;
    redirect_pc = 16'hFFFE;
    step();
    redirect = 1'b0;
    repeat (8) step();
    chk("t5_pc0", pop_pc(0), 32'hFFFE);
    chk("t5_pc1", pop_pc(1), 32'hFFFF);
    chk("t5_pc2", pop_pc(2), 32'h0000);
    chk("t5_pc3", pop_pc(3), 32'h0001);
    chk("t5_ir0", pop_ir(0), 32'hA4C3);

    // Reset asserted mid-cycle with two reads owed and a word queued.
    do_reset();
    bus.mem_ack   = 1'b1;
    bus.out_ready = 1'b1;
    lat = 2;
    repeat (4) step();
    #2;
    do_reset();
    bus.mem_ack   = 1'b1;
    bus.out_ready = 1'b1;
    lat = 1;
    repeat (6) step();
    chk("t6_restart_pc0", pop_pc(0), 0);
    chk("t6_restart_pc2", pop_pc(2), 2);
    chk("t6_restart_cyc", pop_cyc(0), 2 - BYP);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
